sd_cmd_serial_host: RTL
=======================

# sd_cmd_serial_host

Serial end of the SD command path. It takes a 40-bit command and a 16-bit settings word from the command master over a req/ack handshake, and appends CRC7. It drives the 48-bit frame onto the SD CMD line, then samples and CRC-checks the response. It returns the response and a status word to the master over the same handshake, and sits between the command master and the CMD pad.

## Interface
Parameters:
- NCR_TIMEOUT, 64, cycles allowed between end of turnaround and response start bit.
- INIT_CYCLES, 80, length of the power-up ones sequence (only used with SD_CMD_INIT_SEQ_EN).

Ports (name, direction, width, meaning):
- CLK_PAD_IO  in  1  sole clock; all logic on rising edge.
- RST_PAD_I  in  1  reset; synchronous, active-high.
- GO_IDLE_I  in  1  abort; forces IDLE state next cycle.
- SETTING_IN  in  16  [12] data read, [11] data write, [10:8] turnaround N, [7] CRC check, [6:0] response size (0, 40, 127).
- CMD_IN  in  40  command: start/dir, index, argument.
- REQ_IN  in  1  master request; 2-flop synchronized internally.
- ACK_IN  in  1  master acknowledge; 2-flop synchronized internally.
- REQ_OUT  out  1  status/response valid.
- ACK_OUT  out  1  ready for / accepted command.
- CMD_OUT  out  40  first 40 response bits, MSB = start bit.
- STATUS  out  16  [6] data available, [5] CRC valid, [4] response timeout, [3:0] state code, others 0.
- cmd_dat_i  in  1  CMD pad input.
- cmd_out_o  out  1  CMD pad output data.
- cmd_oe_o  out  1  CMD pad output enable.

## Operation
- Reset values: REQ_OUT 0, ACK_OUT 0, CMD_OUT 0, STATUS 0, cmd_oe_o 0, cmd_out_o 1, both synchronizers 0.
- State codes in STATUS[3:0]: INIT 0, IDLE 1, WRITE 2, DLY 3, READ_WAIT 4, READ 5, FINISH 6.
- INIT: drives cmd_oe_o=1, cmd_out_o=1 for INIT_CYCLES cycles, then goes to IDLE.
- IDLE:
  - ACK_OUT=1 when synced REQ_IN=0.
  - On synced REQ_IN=1 with ACK_OUT=1: latch CMD_IN and SETTING_IN, ACK_OUT=0, clear STATUS[6:4], go to WRITE.
- WRITE:
  - cmd_oe_o=1; 48 bits sent MSB first.
  - Bits 47:8 = latched CMD_IN, bits 7:1 = CRC7, bit 0 = 1.
  - CRC7: polynomial x^7+x^3+1, init 0, computed serially over bits 47:8.
- DLY: cmd_oe_o=0 for N+1 cycles, N = SETTING[10:8].
  - If response size = 0: go to FINISH with STATUS[6]=1, [5]=1.
  - Otherwise go to READ_WAIT.
- READ_WAIT: waits for cmd_dat_i=0, which is the start bit and response bit 0.
  - If no start bit within NCR_TIMEOUT cycles: STATUS[6]=1, [5]=0, [4]=1, go to FINISH.
- READ:
  - Frame length L = 48 for size 40, 136 for size 127.
  - First 40 bits shift into CMD_OUT.
  - CRC7 covers bits L-1:8 for size 40 and bits 127:8 for size 127 (after the 8-bit header). It is compared with bits 7:1.
  - After the end bit: STATUS[6]=1, [5] = CRC match, or 1 when SETTING[7]=0. Go to FINISH.
- FINISH:
  - REQ_OUT=1 until synced ACK_IN=1, then REQ_OUT=0.
  - Waits for synced ACK_IN=0 and REQ_IN=0, then goes to IDLE.
- GO_IDLE_I or reset in any state: next state IDLE (or INIT after reset when the macro is defined). cmd_oe_o=0, REQ_OUT=0, ACK_OUT=0 that cycle. CMD_OUT and STATUS[6:4] hold.
- REQ_IN asserted outside IDLE is ignored.

## Timing
- REQ_IN/ACK_IN to internal use: 2 cycles.
- IDLE → first frame bit: the cycle after synced REQ_IN is seen.
- WRITE lasts exactly 48 cycles. cmd_oe_o falls the cycle after the stop bit.
- Response sampling: one bit per cycle on the rising edge, start bit included.
- STATUS and CMD_OUT are stable from the first REQ_OUT=1 cycle until the next IDLE exit.

## Configuration
- SD_CMD_INIT_SEQ_EN defined: reset goes to INIT, and INIT_CYCLES ones are driven before the first ACK_OUT.
- SD_CMD_INIT_SEQ_EN undefined: INIT does not exist, reset goes directly to IDLE, and ACK_OUT=1 on the first cycle after reset release.

## Test plan
- Reset release with SD_CMD_INIT_SEQ_EN → cmd_oe_o=1, cmd_out_o=1 for 80 cycles, then ACK_OUT=1; without the macro, ACK_OUT=1 on the first cycle after release.
- CMD_IN=0x4000000000, size 0 → pad frame 0x400000000095, then REQ_OUT=1 with STATUS[6:4]=110.
- CMD_IN=0x48000001AA, size 40, CRC check on, card returns 0x08000001AA13 after 3 idle cycles → CMD_OUT=0x08000001AA, STATUS[6:4]=110.
- Same command, response CRC byte corrupted to 0x15 → STATUS[5]=0; with SETTING[7]=0 → STATUS[5]=1.
- Size 40 and cmd_dat_i held 1 → after 64 cycles STATUS[6:4]=101 and REQ_OUT=1.
- GO_IDLE_I pulsed at bit 20 of WRITE → cmd_oe_o=0 next cycle, ACK_OUT=1 once REQ_IN is low, and the next command transmits correctly.

Source files
------------

// File: rtl/sd_cmd_serial_host.sv
// SD CMD-line serialiser: sends a 48-bit command frame with CRC7, then captures and CRC-checks the response.
// Optional power-up ones sequence on the pad is enabled with `define SD_CMD_INIT_SEQ_EN.
module sd_cmd_serial_host #(
  parameter int NCR_TIMEOUT = 64,
  parameter int INIT_CYCLES = 80
) (
  input  logic        CLK_PAD_IO,
  input  logic        RST_PAD_I,
  input  logic        GO_IDLE_I,
  input  logic [15:0] SETTING_IN,
  input  logic [39:0] CMD_IN,
  input  logic        REQ_IN,
  input  logic        ACK_IN,
  output logic        REQ_OUT,
  output logic        ACK_OUT,
  output logic [39:0] CMD_OUT,
  output logic [15:0] STATUS,
  input  logic        cmd_dat_i,
  output logic        cmd_out_o,
  output logic        cmd_oe_o
);

  typedef enum logic [3:0] {
    ST_INIT      = 4'd0,
    ST_IDLE      = 4'd1,
    ST_WRITE     = 4'd2,
    ST_DLY       = 4'd3,
    ST_READ_WAIT = 4'd4,
    ST_READ      = 4'd5,
    ST_FINISH    = 4'd6
  } state_t;

`ifdef SD_CMD_INIT_SEQ_EN
  localparam state_t      RST_STATE = ST_INIT;
  localparam logic [15:0] INIT_LAST = 16'(INIT_CYCLES - 1);
`else
  localparam state_t      RST_STATE = ST_IDLE;
  localparam int          unused_init_cycles = INIT_CYCLES;
`endif
  localparam logic [15:0] NCR_LAST = 16'(NCR_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        req_s1, req_s2, ack_s1, ack_s2;
  logic [15:0] cnt;
  logic [10:0] setting;
  logic [47:0] tx_sh;
  logic [39:0] rx_sh;
  logic [6:0]  crc, rx_crc;
  logic [2:0]  flags;
  logic [3:0]  code;
  logic        ack_out, req_out;
  logic        unused_setting;

  logic        start_cmd, no_rsp, long_rsp, dly_done, ncr_expired, rd_done, fin_done, crc_ok;
  logic [15:0] last_idx, crc_first, crc_last, rxcrc_first, rd_idx;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  function automatic logic [6:0] crc7_cmd(input logic [39:0] d);
    logic [6:0] c;
    c = 7'd0;
    for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
    return c;
  endfunction

  assign unused_setting = ^SETTING_IN[15:11];

  // Response geometry in received-bit indices (index 0 = start bit)
  assign long_rsp    = (setting[6:0] == 7'd127);
  assign no_rsp      = (setting[6:0] == 7'd0);
  assign last_idx    = long_rsp ? 16'd135 : 16'd47;
  assign crc_first   = long_rsp ? 16'd8 : 16'd0;
  assign crc_last    = last_idx - 16'd8;
  assign rxcrc_first = last_idx - 16'd7;
  assign rd_idx      = cnt + 16'd1;

  assign start_cmd   = (state == ST_IDLE) && req_s2 && ack_out;
  assign dly_done    = (cnt == {13'd0, setting[10:8]});
  assign ncr_expired = (cnt == NCR_LAST);
  assign rd_done     = (rd_idx == last_idx);
  assign fin_done    = !req_out && !ack_s2 && !req_s2;
  assign crc_ok      = (crc == rx_crc) || !setting[7];

  always_comb begin
    state_nxt = state;
    case (state)
`ifdef SD_CMD_INIT_SEQ_EN
      ST_INIT:      if (cnt == INIT_LAST) state_nxt = ST_IDLE;
`endif
      ST_IDLE:      if (start_cmd) state_nxt = ST_WRITE;
      ST_WRITE:     if (cnt == 16'd47) state_nxt = ST_DLY;
      ST_DLY:       if (dly_done) state_nxt = no_rsp ? ST_FINISH : ST_READ_WAIT;
      ST_READ_WAIT: begin
        if (!cmd_dat_i)       state_nxt = ST_READ;
        else if (ncr_expired) state_nxt = ST_FINISH;
      end
      ST_READ:      if (rd_done) state_nxt = ST_FINISH;
      ST_FINISH:    if (fin_done) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
    if (GO_IDLE_I) state_nxt = ST_IDLE;
  end

  always_ff @(posedge CLK_PAD_IO) begin
    if (RST_PAD_I) state <= RST_STATE;
    else           state <= state_nxt;
  end

  always_ff @(posedge CLK_PAD_IO) begin
    if (RST_PAD_I) begin
      req_s1  <= 1'b0;
      req_s2  <= 1'b0;
      ack_s1  <= 1'b0;
      ack_s2  <= 1'b0;
      cnt     <= 16'd0;
      code    <= 4'd0;
      flags   <= 3'd0;
      ack_out <= 1'b0;
      req_out <= 1'b0;
      CMD_OUT <= 40'd0;
    end else begin
      req_s1 <= REQ_IN;
      req_s2 <= req_s1;
      ack_s1 <= ACK_IN;
      ack_s2 <= ack_s1;
      code   <= state_nxt;
      cnt    <= (state_nxt != state) ? 16'd0 : cnt + 16'd1;
      if (GO_IDLE_I) begin
        ack_out <= 1'b0;
        req_out <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_cmd) begin
              setting <= SETTING_IN[10:0];
              tx_sh   <= {CMD_IN, crc7_cmd(CMD_IN), 1'b1};
              ack_out <= 1'b0;
              flags   <= 3'd0;
            end else if (!req_s2) begin
              ack_out <= 1'b1;
            end
          end
          ST_WRITE: tx_sh <= {tx_sh[46:0], 1'b1};
          ST_DLY: begin
            crc <= 7'd0;
            if (dly_done && no_rsp) begin
              flags   <= 3'b110;
              req_out <= 1'b1;
            end
          end
          // Start bit is response bit 0; its CRC contribution is zero
          ST_READ_WAIT: begin
            crc <= 7'd0;
            if (!cmd_dat_i) begin
              rx_sh <= {rx_sh[38:0], 1'b0};
            end else if (ncr_expired) begin
              flags   <= 3'b101;
              req_out <= 1'b1;
            end
          end
          ST_READ: begin
            if (rd_idx < 16'd40) rx_sh <= {rx_sh[38:0], cmd_dat_i};
            if (rd_idx >= crc_first && rd_idx <= crc_last) crc <= crc7_step(crc, cmd_dat_i);
            if (rd_idx >= rxcrc_first && rd_idx < last_idx) rx_crc <= {rx_crc[5:0], cmd_dat_i};
            if (rd_done) begin
              CMD_OUT <= rx_sh;
              flags   <= {1'b1, crc_ok, 1'b0};
              req_out <= 1'b1;
            end
          end
          ST_FINISH: if (ack_s2) req_out <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign ACK_OUT   = ack_out;
  assign REQ_OUT   = req_out;
  assign STATUS    = {9'd0, flags, code};
  assign cmd_out_o = (state == ST_WRITE) ? tx_sh[47] : 1'b1;
`ifdef SD_CMD_INIT_SEQ_EN
  assign cmd_oe_o  = (state == ST_WRITE) || ((state == ST_INIT) && !RST_PAD_I);
`else
  assign cmd_oe_o  = (state == ST_WRITE);
`endif

endmodule
